// File: rtl/ccsds123_ctrl_pkg.sv
// Shared state type, sizing helpers and counter width for the CCSDS-123 frame controller.
package ccsds123_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWaitEnd
    } ctrl_state_e;

    localparam int unsigned PerfCntW = 32;

    function automatic int unsigned calc_beats(input int unsigned nx, input int unsigned ny,
                                               input int unsigned nz,
                                               input int unsigned pipelines);
        return (nx * ny * nz) / pipelines;
    endfunction

    function automatic logic [PerfCntW-1:0] sat_inc(input logic [PerfCntW-1:0] v,
                                                    input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/ccsds123_frame_ctrl_if.sv
// Host-sample stream, compressor-input beat stream and compressor-output taps.
interface ccsds123_frame_ctrl_if #(
    parameter int unsigned PIPELINES = 4,
    parameter int unsigned D         = 16
) ();
    logic [D-1:0]           s_tdata;
    logic                   s_tvalid;
    logic                   s_tready;
    logic [PIPELINES*D-1:0] m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;
    logic                   mon_tvalid;
    logic                   mon_tlast;

    modport master (
        output s_tdata, s_tvalid, m_tready, mon_tvalid, mon_tlast,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  s_tdata, s_tvalid, m_tready, mon_tvalid, mon_tlast,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/ccsds123_lane_packer.sv
// Packs consecutive samples into a PIPELINES-wide beat and owns the m_* handshake.
module ccsds123_lane_packer
    import ccsds123_ctrl_pkg::*;
#(
    parameter int unsigned PIPELINES = 4,
    parameter int unsigned D         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   fill_i,
    input  logic                   load_last_i,
    input  logic [D-1:0]           s_tdata_i,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    output logic [PIPELINES*D-1:0] m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic                   beat_done_o
);
    localparam int unsigned LaneW = (PIPELINES > 1) ? $clog2(PIPELINES) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(PIPELINES - 1);

    logic [LaneW-1:0]       lane_q;
    logic [PIPELINES*D-1:0] data_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   accept;

    // Lanes are only written while no beat is pending or the pending beat leaves this cycle,
    // so the beat register doubles as the assembly buffer without disturbing a stalled beat.
    assign s_tready_o  = fill_i && (!valid_q || m_tready_i);
    assign accept      = s_tready_o && s_tvalid_i;
    assign beat_done_o = valid_q && m_tready_i;
    assign m_tdata_o   = data_q;
    assign m_tvalid_o  = valid_q;
    assign m_tlast_o   = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            lane_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (beat_done_o) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (accept) begin
                for (int k = 0; k < int'(PIPELINES); k++) begin
                    if (lane_q == LaneW'(k)) data_q[k*D +: D] <= s_tdata_i;
                end
                if (lane_q == LastLane) begin
                    lane_q  <= '0;
                    valid_q <= 1'b1;
                    last_q  <= load_last_i;
                end else begin
                    lane_q <= lane_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/ccsds123_frame_ctrl.sv
// Frame sequencer in front of ccsds123_top: counts one NX*NY*NZ image per frame and waits for
// the compressor's final word. Define CCSDS123_FRAME_CTRL_PERF_EN to add performance counters.
module ccsds123_frame_ctrl
    import ccsds123_ctrl_pkg::*;
#(
    parameter int unsigned PIPELINES = 4,
    parameter int unsigned D         = 16,
    parameter int unsigned NX        = 16,
    parameter int unsigned NY        = 16,
    parameter int unsigned NZ        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [15:0]          frame_count_o,
    ccsds123_frame_ctrl_if.slave bus
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
    ,
    output logic [PerfCntW-1:0]  perf_stall_cycles_o,
    output logic [PerfCntW-1:0]  perf_total_cycles_o,
    output logic [PerfCntW-1:0]  perf_out_valid_cycles_o
`endif
);
    localparam int unsigned NumSamples = NX * NY * NZ;
    localparam int unsigned Beats      = calc_beats(NX, NY, NZ, PIPELINES);
    localparam int unsigned SampleW    = (NumSamples > 1) ? $clog2(NumSamples) : 1;
    localparam logic [SampleW-1:0] LastSample = SampleW'(NumSamples - 1);

    if (Beats * PIPELINES != NumSamples) begin : g_dim_check
        $error("NX*NY*NZ must be a multiple of PIPELINES");
    end

    ctrl_state_e            state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [15:0]            frame_cnt_q;
    logic [SampleW-1:0]     sample_cnt_q;
    logic                   fill, clear, load_last, sample_accept, beat_done, end_seen;
    logic                   s_tready, m_tvalid, m_tlast;
    logic [PIPELINES*D-1:0] m_tdata;

    // Once the final beat is loaded no further samples belong to this frame.
    assign fill          = (state_q == StFill) && !m_tlast;
    assign clear         = abort_i || ((state_q == StIdle) && start_i);
    assign load_last     = (sample_cnt_q == LastSample);
    assign sample_accept = bus.s_tvalid && s_tready;
    assign end_seen      = bus.mon_tvalid && bus.mon_tlast;

    ccsds123_lane_packer #(
        .PIPELINES(PIPELINES),
        .D        (D)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .fill_i     (fill),
        .load_last_i(load_last),
        .s_tdata_i  (bus.s_tdata),
        .s_tvalid_i (bus.s_tvalid),
        .s_tready_o (s_tready),
        .m_tdata_o  (m_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (bus.m_tready),
        .m_tlast_o  (m_tlast),
        .beat_done_o(beat_done)
    );

    assign bus.s_tready  = s_tready;
    assign bus.m_tdata   = m_tdata;
    assign bus.m_tvalid  = m_tvalid;
    assign bus.m_tlast   = m_tlast;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign frame_count_o = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_cnt_q  <= '0;
            sample_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q      <= StFill;
                            busy_q       <= 1'b1;
                            sample_cnt_q <= '0;
                        end
                    end
                    StFill: begin
                        if (sample_accept && !load_last) sample_cnt_q <= sample_cnt_q + 1'b1;
                        if (beat_done && m_tlast) state_q <= StWaitEnd;
                    end
                    StWaitEnd: begin
                        if (end_seen) begin
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef CCSDS123_FRAME_CTRL_PERF_EN
    logic [PerfCntW-1:0] stall_q, total_q, outv_q;

    always_ff @(posedge clk) begin
        if (rst || ((state_q == StIdle) && start_i && !abort_i)) begin
            stall_q <= '0;
            total_q <= '0;
            outv_q  <= '0;
        end else begin
            stall_q <= sat_inc(stall_q, (state_q == StFill) && bus.s_tvalid && !s_tready);
            total_q <= sat_inc(total_q, state_q != StIdle);
            outv_q  <= sat_inc(outv_q, bus.mon_tvalid && busy_q);
        end
    end

    assign perf_stall_cycles_o     = stall_q;
    assign perf_total_cycles_o     = total_q;
    assign perf_out_valid_cycles_o = outv_q;
`endif
endmodule

// File: tb/tb_ccsds123_frame_ctrl.sv
// Self-checking bench for ccsds123_frame_ctrl: beats are predicted as consecutive groups of
// accepted samples; frame/abort/reset behaviour is checked with directed steps.
module tb_ccsds123_frame_ctrl;
    localparam int unsigned P     = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned NSAMP = 16 * 16 * 8;
    localparam int unsigned BEATS = NSAMP / P;

    logic        clk = 1'b0;
    logic        rst, start, abort, busy, done;
    logic [15:0] frame_count;
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
    logic [31:0] perf_stall, perf_total, perf_outv;
`endif

    ccsds123_frame_ctrl_if #(.PIPELINES(P), .D(DW)) bus ();

    ccsds123_frame_ctrl #(
        .PIPELINES(P),
        .D        (DW),
        .NX       (16),
        .NY       (16),
        .NZ       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .frame_count_o(frame_count),
        .bus          (bus)
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
        ,
        .perf_stall_cycles_o    (perf_stall),
        .perf_total_cycles_o    (perf_total),
        .perf_out_valid_cycles_o(perf_outv)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned vprob, rprob;
    bit          rand_data;
    int unsigned gen_idx;
    logic [15:0] cur_data;
    logic [15:0] acc[$];
    int          beat_idx, step_no, gap_bad, ready_cycles;
    bit          hold_pending;
    logic [63:0] hold_data, first_beat;
    logic        hold_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic next_data();
        cur_data    = rand_data ? 16'($urandom) : 16'(gen_idx);
        bus.s_tdata = cur_data;
    endtask

    task automatic drive();
        bus.s_tvalid = ($urandom_range(99) < vprob);
        bus.m_tready = ($urandom_range(99) < rprob);
    endtask

    task automatic new_frame_model();
        acc.delete();
        beat_idx     = 0;
        gen_idx      = 0;
        step_no      = 0;
        gap_bad      = 0;
        ready_cycles = 0;
        hold_pending = 0;
        first_beat   = 'x;
        next_data();
        drive();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    // One clock: predict handshakes from settled inputs, advance, then drive the next cycle.
    task automatic step();
        logic        s_hs, m_hs;
        logic [63:0] exp_beat;
        if (hold_pending) begin
            chk("hold_valid", 64'(bus.m_tvalid), 64'(1'b1));
            chk("hold_data", bus.m_tdata, hold_data);
            chk("hold_last", 64'(bus.m_tlast), 64'(hold_last));
            hold_pending = 0;
        end
        s_hs = bus.s_tvalid && bus.s_tready;
        m_hs = bus.m_tvalid && bus.m_tready;
        if (bus.s_tready) ready_cycles++;
        if (bus.m_tvalid && !bus.m_tready) begin
            hold_pending = 1;
            hold_data    = bus.m_tdata;
            hold_last    = bus.m_tlast;
        end
        if (m_hs) begin
            if (acc.size() < int'(P)) begin
                chk("beat_underflow", 64'(acc.size()), 64'(P));
            end else begin
                exp_beat = '0;
                for (int k = 0; k < int'(P); k++) exp_beat[k*DW +: DW] = acc.pop_front();
                chk("beat_data", bus.m_tdata, exp_beat);
                chk("beat_last", 64'(bus.m_tlast), 64'(beat_idx == int'(BEATS) - 1));
                if (step_no != 4 * beat_idx + 4) gap_bad++;
                if (beat_idx == 0) first_beat = bus.m_tdata;
                beat_idx++;
            end
        end
        if (s_hs) begin
            acc.push_back(cur_data);
            gen_idx++;
        end
        tick();
        step_no++;
        if (s_hs) next_data();
        drive();
        #1;
    endtask

    task automatic run_frame(input int budget, input int early_at);
        while (beat_idx < int'(BEATS) && budget > 0) begin
            if (step_no == early_at) begin
                bus.mon_tvalid = 1'b1;
                bus.mon_tlast  = 1'b1;
                step();
                bus.mon_tvalid = 1'b0;
                bus.mon_tlast  = 1'b0;
                chk("early_tlast_no_done", 64'(done), 64'(1'b0));
            end else begin
                step();
            end
            budget--;
        end
        chk("frame_beats", 64'(beat_idx), 64'(BEATS));
        chk("samples_taken", 64'(gen_idx), 64'(NSAMP));
    endtask

    task automatic finish_frame(input logic [15:0] exp_count);
        chk("wait_end_sready", 64'(bus.s_tready), 64'(1'b0));
        chk("wait_end_mvalid", 64'(bus.m_tvalid), 64'(1'b0));
        chk("wait_end_busy", 64'(busy), 64'(1'b1));
        bus.mon_tvalid = 1'b1;
        bus.mon_tlast  = 1'b0;
        tick();
        chk("no_done_without_tlast", 64'(done), 64'(1'b0));
        bus.mon_tlast = 1'b1;
        tick();
        bus.mon_tvalid = 1'b0;
        bus.mon_tlast  = 1'b0;
        #1;
        chk("done_pulse", 64'(done), 64'(1'b1));
        chk("done_clears_busy", 64'(busy), 64'(1'b0));
        chk("frame_count", 64'(frame_count), 64'(exp_count));
        tick();
        chk("done_one_cycle", 64'(done), 64'(1'b0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_done"}, 64'(done), 64'(1'b0));
        chk({tag, "_frame_count"}, 64'(frame_count), 64'(0));
        chk({tag, "_s_tready"}, 64'(bus.s_tready), 64'(1'b0));
        chk({tag, "_m_tvalid"}, 64'(bus.m_tvalid), 64'(1'b0));
        chk({tag, "_m_tlast"}, 64'(bus.m_tlast), 64'(1'b0));
        chk({tag, "_m_tdata"}, bus.m_tdata, 64'(0));
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        bus.s_tdata    = '0;
        bus.s_tvalid   = 1'b1;
        bus.m_tready   = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tlast  = 1'b0;
        vprob          = 100;
        rprob          = 100;
        rand_data      = 0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("idle_no_sready", 64'(bus.s_tready), 64'(1'b0));

        // Abort beats start; monitor tlast in IDLE is ignored.
        bus.mon_tvalid = 1'b1;
        bus.mon_tlast  = 1'b1;
        start          = 1'b1;
        abort          = 1'b1;
        tick();
        start          = 1'b0;
        abort          = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tlast  = 1'b0;
        #1;
        chk("abort_wins_busy", 64'(busy), 64'(1'b0));
        chk("idle_mon_no_done", 64'(done), 64'(1'b0));

        // Frame 1: nominal ramp at full throughput.
        new_frame_model();
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'(1'b1));
        run_frame(6000, -1);
        chk("first_beat_ramp", first_beat, 64'h0003_0002_0001_0000);
        chk("full_rate_ready", 64'(ready_cycles), 64'(NSAMP));
        chk("beat_spacing", 64'(gap_bad), 64'(0));
        finish_frame(16'd1);

        // Frame 2: back-to-back, random data, backpressure, early monitor tlast.
        rand_data = 1;
        vprob     = 80;
        rprob     = 30;
        new_frame_model();
        pulse_start();
        run_frame(20000, 100);
        finish_frame(16'd2);
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
        chk("perf_stall_nonzero", 64'(perf_stall != 0), 64'(1'b1));
        chk("perf_total_nonzero", 64'(perf_total != 0), 64'(1'b1));
        chk("perf_out_valid", 64'(perf_outv), 64'(3));
`endif

        // Frame 3: abort after sample 2 of beat 10.
        rand_data = 0;
        vprob     = 100;
        rprob     = 100;
        new_frame_model();
        pulse_start();
        for (int i = 0; i < 200 && gen_idx < 43; i++) step();
        chk("abort_point_beats", 64'(beat_idx), 64'(10));
        abort = 1'b1;
        tick();
        abort        = 1'b0;
        hold_pending = 0;
        #1;
        chk("abort_busy", 64'(busy), 64'(1'b0));
        chk("abort_m_tvalid", 64'(bus.m_tvalid), 64'(1'b0));
        chk("abort_m_tlast", 64'(bus.m_tlast), 64'(1'b0));
        chk("abort_s_tready", 64'(bus.s_tready), 64'(1'b0));
        chk("abort_no_done", 64'(done), 64'(1'b0));
        chk("abort_frame_count", 64'(frame_count), 64'(2));
        tick();
        chk("abort_no_done_later", 64'(done), 64'(1'b0));

        // Restart after abort, run to WAIT_END, then reset there.
        new_frame_model();
        pulse_start();
        run_frame(6000, -1);
        chk("restart_first_beat", first_beat, 64'h0003_0002_0001_0000);
        chk("restart_wait_busy", 64'(busy), 64'(1'b1));
        rst = 1'b1;
        tick();
        chk_reset_outputs("wait_end_reset");
        rst = 1'b0;
        tick();
        chk("post_reset_idle", 64'(busy), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
